// File: rtl/rv_pkg.sv
// Shared RV32 front-end definitions: data width, decoder opcodes and the
// fetch-queue entry layout used between fetch and decode.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, inst} entries; flush wins over
// push and pop so a redirect empties it in a single edge.
module fetch_queue
    import rv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output fetch_entry_t head_data,
    output logic         full,
    output logic         empty,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // NOTE: storage has no reset; occupancy is tracked by r_count and outputs are gated on empty.
    always_ff @(posedge clk) begin
        if (w_push && !flush) r_mem[r_wr_ptr] <= push_data;
    end

    assign head_data = r_mem[r_rd_ptr];
    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues credit-limited in-order
// memory requests, queues responses and handles execute redirects.
module instr_fetch_unit
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_inst,
    output logic [XLEN-1:0] if_pc,
    output logic [6:0]      if_opcode
);

    localparam int OW = $clog2(QDEPTH + 1);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [OW-1:0]   r_outstanding;
    logic [OW-1:0]   r_drop_cnt;

    logic [OW-1:0]   w_q_count;
    logic [OW:0]     w_in_flight;
    logic            w_q_full;
    logic            w_q_empty;
    logic            w_accept;
    logic            w_keep_rsp;
    logic [XLEN-1:0] w_redirect_pc;
    fetch_entry_t    w_push_data;
    fetch_entry_t    w_head;

    // Queued plus outstanding fetches never exceed QDEPTH, so a response always has a slot.
    assign w_in_flight    = {1'b0, w_q_count} + {1'b0, r_outstanding};
    assign imem_req_valid = !rst && !redirect_valid && (w_in_flight < (OW + 1)'(QDEPTH));
    assign imem_req_addr  = r_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    assign w_redirect_pc  = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_keep_rsp     = imem_rsp_valid && !redirect_valid && (r_drop_cnt == '0);
    assign w_push_data    = '{pc: r_rsp_pc, inst: imem_rsp_data};

    fetch_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (w_keep_rsp),
        .pop       (if_ready),
        .flush     (redirect_valid),
        .push_data (w_push_data),
        .head_data (w_head),
        .full      (w_q_full),
        .empty     (w_q_empty),
        .count     (w_q_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= r_outstanding + OW'(w_accept) - OW'(imem_rsp_valid);
            if (redirect_valid) begin
                // A response landing this edge is already discarded, so exclude it.
                r_pc       <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
                r_drop_cnt <= r_outstanding - OW'(imem_rsp_valid);
            end else begin
                if (w_accept) r_pc <= r_pc + XLEN'(4);
                if (imem_rsp_valid) begin
                    if (r_drop_cnt != '0) r_drop_cnt <= r_drop_cnt - OW'(1);
                    else                  r_rsp_pc   <= r_rsp_pc + XLEN'(4);
                end
            end
        end
    end

    assign if_valid  = !w_q_empty;
    assign if_inst   = w_q_empty ? '0 : w_head.inst;
    assign if_pc     = w_q_empty ? '0 : w_head.pc;
    assign if_opcode = if_inst[6:0];

    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(w_keep_rsp && w_q_full));
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
                                      !(imem_rsp_valid && (r_outstanding == '0)));

endmodule
